// File: rtl/mul_seq_hs_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_hs_if
//  Purpose  : valid/ready operand and product bundle for mul_seq_hs
//  Revision : 1.0  initial release
// ============================================================================
interface mul_seq_hs_if #(
    parameter int WIDTH = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 busy;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface
`default_nettype wire

// File: rtl/mul_seq_hs.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq_hs
//  Purpose  : sequential WIDTH x WIDTH multiplier, DIGIT bits of B per cycle
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq_hs #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mul_seq_hs_if.slave hs
);
    localparam int c_n    = WIDTH / DIGIT;
    localparam int c_cw   = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("mul_seq_hs: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [2*WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]     r_b_sh;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_cw-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [DIGIT-1:0]     w_slice;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_sum;

    // Negating -2^(WIDTH-1) wraps back to itself, which read unsigned is the correct magnitude.
    assign w_a_mag = (hs.in_signed && hs.in_a[WIDTH-1]) ? -hs.in_a : hs.in_a;
    assign w_b_mag = (hs.in_signed && hs.in_b[WIDTH-1]) ? -hs.in_b : hs.in_b;

    // A is pre-shifted and B post-shifted so each partial product needs no variable shifter.
    assign w_slice = r_b_sh[DIGIT-1:0];
    assign w_pp    = r_a_sh * {{(2*WIDTH-DIGIT){1'b0}}, w_slice};
    assign w_sum   = r_acc + w_pp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_neg   <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (hs.in_valid) begin
                        r_a_sh  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_b_sh  <= w_b_mag;
                        r_neg   <= hs.in_signed & (hs.in_a[WIDTH-1] ^ hs.in_b[WIDTH-1]);
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= c_st_calc;
                    end
                end
                c_st_calc: begin
                    r_acc   <= w_sum;
                    r_a_sh  <= r_a_sh << DIGIT;
                    r_b_sh  <= r_b_sh >> DIGIT;
                    r_count <= r_count + c_cw'(1);
                    if (r_count == c_last) begin
                        r_p     <= r_neg ? -w_sum : w_sum;
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (hs.out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign hs.in_ready  = (r_state == c_st_idle);
    assign hs.out_valid = (r_state == c_st_done);
    assign hs.busy      = (r_state != c_st_idle);
    assign hs.out_p     = r_p;
endmodule
`default_nettype wire

// File: tb/tb_mul_seq_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_seq_hs
//  Purpose  : scoreboard bench for mul_seq_hs at DIGIT 1/4/16 (WIDTH 16) and WIDTH 8
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_seq_hs;
    // index 0: W16/D1, 1: W16/D4, 2: W16/D16, 3: W8/D4
    localparam int c_n [4] = '{16, 4, 1, 2};
    localparam int c_dig [3] = '{1, 4, 16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic [15:0] a16 = '0, b16 = '0;
    logic        s16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        s8 = 1'b0;
    logic [3:0]  r_v = '0;
    logic [3:0]  r_ordy = 4'hF;

    logic [3:0]  w_rdy, w_ov, w_bsy;
    logic [31:0] w_p [4];

    logic [31:0] q_exp  [4][$];
    int          q_edge [4][$];
    bit          lat_done [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_hs_if #(.WIDTH(16)) bus16 [3] ();
    mul_seq_hs_if #(.WIDTH(8))  bus8 ();

    generate
        for (genvar k = 0; k < 3; k++) begin : g_w16
            assign bus16[k].in_valid  = r_v[k];
            assign bus16[k].in_a      = a16;
            assign bus16[k].in_b      = b16;
            assign bus16[k].in_signed = s16;
            assign bus16[k].out_ready = r_ordy[k];
            assign w_rdy[k] = bus16[k].in_ready;
            assign w_ov[k]  = bus16[k].out_valid;
            assign w_bsy[k] = bus16[k].busy;
            assign w_p[k]   = bus16[k].out_p;
            mul_seq_hs #(.WIDTH(16), .DIGIT(c_dig[k])) u_dut (
                .clk (clk),
                .rst (rst),
                .hs  (bus16[k])
            );
        end
    endgenerate

    assign bus8.in_valid  = r_v[3];
    assign bus8.in_a      = a8;
    assign bus8.in_b      = b8;
    assign bus8.in_signed = s8;
    assign bus8.out_ready = r_ordy[3];
    assign w_rdy[3] = bus8.in_ready;
    assign w_ov[3]  = bus8.out_valid;
    assign w_bsy[3] = bus8.busy;
    assign w_p[3]   = {16'b0, bus8.out_p};

    mul_seq_hs #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .hs  (bus8)
    );

    function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
        longint sa, sb, p;
        if (w == 8) begin
            sa = s ? longint'($signed(a[7:0])) : longint'(a[7:0]);
            sb = s ? longint'($signed(b[7:0])) : longint'(b[7:0]);
        end else begin
            sa = s ? longint'($signed(a)) : longint'(a);
            sb = s ? longint'($signed(b)) : longint'(b);
        end
        p = sa * sb;
        return (w == 8) ? {16'b0, p[15:0]} : p[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input logic [3:0] mask);
        int n = 0;
        while (((w_rdy & mask) != mask) && n < 60) begin
            step();
            n++;
        end
        chk("in_ready_timeout", {28'b0, w_rdy & mask}, {28'b0, mask});
    endtask

    task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input logic s);
        wait_rdy(4'b0001 << k);
        if (k == 3) begin
            a8 = a[7:0]; b8 = b[7:0]; s8 = s;
        end else begin
            a16 = a; b16 = b; s16 = s;
        end
        r_v[k] = 1'b1;
        step();
        r_v[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q_exp[0].size() + q_exp[1].size() + q_exp[2].size() + q_exp[3].size() != 0
                || w_rdy != 4'hF) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(q_exp[0].size() + q_exp[1].size() + q_exp[2].size()
                                 + q_exp[3].size()), 32'd0);
    endtask

    initial begin
        int n, nacc, last;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    for (int k = 0; k < 4; k++) begin
                        if (w_ov[k] && !lat_done[k]) begin
                            if (q_exp[k].size() == 0)
                                chk("valid_without_op", {31'b0, w_ov[k]}, 32'd0);
                            else
                                chk("latency", 32'(cyc - q_edge[k][0]), 32'(c_n[k]));
                            lat_done[k] = 1'b1;
                        end
                        if (w_ov[k] && r_ordy[k] && q_exp[k].size() != 0) begin
                            chk("product", w_p[k], q_exp[k].pop_front());
                            void'(q_edge[k].pop_front());
                            lat_done[k] = 1'b0;
                        end
                        if (r_v[k] && w_rdy[k]) begin
                            q_exp[k].push_back((k == 3) ? model(8, {8'b0, a8}, {8'b0, b8}, s8)
                                                        : model(16, a16, b16, s16));
                            q_edge[k].push_back(cyc + 1);
                        end
                    end
                end
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_in_ready",  {31'b0, w_rdy[k]}, 32'd1);
            chk("rst_out_valid", {31'b0, w_ov[k]},  32'd0);
            chk("rst_busy",      {31'b0, w_bsy[k]}, 32'd0);
            chk("rst_out_p",     w_p[k],            32'd0);
        end
        step();
        rst = 1'b0;

        // WIDTH=8 unsigned and signed corner cases
        op(3, 16'd255, 16'd255, 1'b0);  drain(); chk("w8_255x255",    w_p[3], 32'h0000FE01);
        op(3, 16'h80, 16'h80, 1'b1);    drain(); chk("w8_m128xm128",  w_p[3], 32'h00004000);
        op(3, 16'h80, 16'h7F, 1'b1);    drain(); chk("w8_m128x127",   w_p[3], 32'h0000C080);
        op(3, 16'hFF, 16'h01, 1'b1);    drain(); chk("w8_m1x1",       w_p[3], 32'h0000FFFF);
        op(1, 16'h8000, 16'h8000, 1'b1); drain(); chk("w16_min_sq",   w_p[1], 32'h40000000);
        op(1, 16'hFFFF, 16'h0001, 1'b1); drain(); chk("w16_m1x1",     w_p[1], 32'hFFFFFFFF);
        op(1, 16'hFFFF, 16'hFFFF, 1'b0); drain(); chk("w16_max_sq",   w_p[1], 32'hFFFE0001);

        // DONE held for 10 cycles with stray in_valid pulses
        r_ordy[1] = 1'b0;
        op(1, 16'd1000, 16'd300, 1'b0);
        n = 0;
        while (!w_ov[1] && n < 20) begin
            step();
            n++;
        end
        chk("done_wait", {31'b0, w_ov[1]}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'b0, w_ov[1]},  32'd1);
            chk("hold_out_p",     w_p[1],            32'd300000);
            chk("hold_in_ready",  {31'b0, w_rdy[1]}, 32'd0);
            chk("hold_busy",      {31'b0, w_bsy[1]}, 32'd1);
            step();
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            r_v[1] = (i % 2 == 1);
        end
        r_v[1] = 1'b0;
        r_ordy[1] = 1'b1;
        step();
        @(negedge clk);
        chk("release_in_ready",  {31'b0, w_rdy[1]}, 32'd1);
        chk("release_out_valid", {31'b0, w_ov[1]},  32'd0);
        chk("retain_out_p",      w_p[1],            32'd300000);
        step();
        op(1, 16'd7, 16'd9, 1'b0);
        drain();
        chk("after_hold_p", w_p[1], 32'd63);

        // reset during the second CALC cycle drops the operation
        op(1, 16'd1111, 16'd2222, 1'b0);
        step();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q_exp[k].delete();
            q_edge[k].delete();
            lat_done[k] = 1'b0;
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready",  {31'b0, w_rdy[1]}, 32'd1);
        chk("midrst_out_valid", {31'b0, w_ov[1]},  32'd0);
        chk("midrst_out_p",     w_p[1],            32'd0);
        chk("midrst_busy",      {31'b0, w_bsy[1]}, 32'd0);
        step();
        op(1, 16'd1234, 16'd5678, 1'b0);
        drain();
        chk("post_rst_p", w_p[1], 32'd7006652);

        // in_valid held high: IDLE, N CALC and one DONE cycle separate accept edges
        r_v[1] = 1'b1;
        nacc = 0;
        last = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (w_rdy[1]) begin
                if (nacc > 0) chk("b2b_spacing", 32'(cyc + 1 - last), 32'(c_n[1] + 2));
                last = cyc + 1;
                nacc++;
            end
            step();
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            s16 = 1'($urandom_range(0, 1));
        end
        r_v[1] = 1'b0;
        chk("b2b_count", 32'(nacc), 32'd9);
        drain();

        // random ops applied to DIGIT=1, 4 and 16 simultaneously
        for (int i = 0; i < 500; i++) begin
            wait_rdy(4'b0111);
            case (i)
                0:       begin a16 = 16'h8000; b16 = 16'h8000; s16 = 1'b1; end
                1:       begin a16 = 16'hFFFF; b16 = 16'hFFFF; s16 = 1'b0; end
                2:       begin a16 = 16'h0000; b16 = 16'h1234; s16 = 1'b1; end
                3:       begin a16 = 16'h8000; b16 = 16'h7FFF; s16 = 1'b1; end
                default: begin
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    s16 = 1'($urandom_range(0, 1));
                end
            endcase
            r_v[2:0] = 3'b111;
            step();
            r_v[2:0] = 3'b000;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
